moore_pattern_detector: RTL and testbench

MOORE_PATTERN_DETECTOR -- requirements
Module: moore_pattern_detector

---
 rtl/moore_detector_pkg.sv | 15 +
 rtl/sat_counter.sv | 32 +++
 rtl/moore_pattern_detector.sv | 112 +++++++++++
 tb/tb_moore_pattern_detector.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/moore_detector_pkg.sv
// Shared constants and helpers for the Moore pattern detector.
//   - legal PATTERN_LEN bounds
//   - default width of the match counter
//   - state_w(): bits needed to hold a state value 0..len
package moore_detector_pkg;

  localparam int PATTERN_LEN_MIN = 2;
  localparam int PATTERN_LEN_MAX = 16;
  localparam int COUNT_W_DEFAULT = 8;

  function automatic int state_w(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Ports:
//   clock - rising-edge clock
//   reset - synchronous active-high reset (count <= 0)
//   clear - synchronous clear (count <= 0), priority over inc
//   inc   - increment request
//   count - current count, COUNT_W bits
module sat_counter
  import moore_detector_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               inc,
  output logic [COUNT_W-1:0] count
);

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + COUNT_W'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/moore_pattern_detector.sv
// Moore-style serial pattern detector using a KMP transition table built
// at elaboration from PATTERN. State = number of pattern bits matched;
// state PATTERN_LEN is MATCH and drives y.
// Optional feature: define MATCH_COUNT_EN to include the match_count port
// and its saturating counter.
// Ports:
//   clock       - rising-edge clock
//   reset       - synchronous active-high reset
//   x, x_valid  - serial data bit and its qualifier
//   clear       - synchronous clear of search state and counter
//   y           - high while in MATCH (decoded from state)
//   match_pulse - one-cycle strobe on every entry to MATCH
//   match_count - saturating match count (MATCH_COUNT_EN only)
module moore_pattern_detector
  import moore_detector_pkg::*;
#(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
  parameter int                     OVERLAP     = 1,
  parameter int                     COUNT_W     = COUNT_W_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               x,
  input  logic               x_valid,
  input  logic               clear,
  output logic               y,
  output logic               match_pulse
`ifdef MATCH_COUNT_EN
  ,
  output logic [COUNT_W-1:0] match_count
`endif
);

  localparam int SW = state_w(PATTERN_LEN);

  if (PATTERN_LEN < PATTERN_LEN_MIN || PATTERN_LEN > PATTERN_LEN_MAX) begin : g_len_check
    $error("moore_pattern_detector: PATTERN_LEN %0d outside legal range", PATTERN_LEN);
  end

  // Longest pattern prefix that is a suffix of (first s pattern bits, then b).
  // For s = PATTERN_LEN the candidate length is capped at PATTERN_LEN, which
  // is exactly the transition from the failure state of the full pattern.
  function automatic int kmp_next(input int s, input int b);
    int kmax;
    int res;
    int j;
    int sb;
    logic ok;
    kmax = (s + 1 > PATTERN_LEN) ? PATTERN_LEN : s + 1;
    res  = 0;
    for (int k = 1; k <= kmax; k++) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++) begin
        j  = s + 1 - k + i;
        sb = (j < s) ? int'(PATTERN[PATTERN_LEN-1-j]) : b;
        if (sb != int'(PATTERN[PATTERN_LEN-1-i])) ok = 1'b0;
      end
      if (ok) res = k;
    end
    return res;
  endfunction

  logic [SW-1:0] trans [0:PATTERN_LEN][0:1];

  for (genvar s = 0; s <= PATTERN_LEN; s++) begin : g_row
    for (genvar b = 0; b < 2; b++) begin : g_col
      // Without overlap, a bit received in MATCH restarts from state 0.
      localparam int NXT = (s == PATTERN_LEN && OVERLAP == 0) ? kmp_next(0, b)
                                                              : kmp_next(s, b);
      assign trans[s][b] = SW'(NXT);
    end
  end

  logic [SW-1:0] state;
  logic [SW-1:0] state_nxt;
  logic          pulse_nxt;

  always_comb begin
    state_nxt = state;
    pulse_nxt = 1'b0;
    if (x_valid) begin
      state_nxt = trans[state][x];
      pulse_nxt = (state_nxt == SW'(PATTERN_LEN));
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state       <= '0;
      match_pulse <= 1'b0;
    end else begin
      state       <= state_nxt;
      match_pulse <= pulse_nxt;
    end
  end

  assign y = (state == SW'(PATTERN_LEN));

`ifdef MATCH_COUNT_EN
  // Counter advances on the same edge that raises match_pulse, so the new
  // count is visible alongside the strobe.
  sat_counter #(.COUNT_W(COUNT_W)) u_count (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .inc   (pulse_nxt),
    .count (match_count)
  );
`endif

endmodule

// File: tb/tb_moore_pattern_detector.sv
// Scoreboard bench for moore_pattern_detector. Three instances share one
// stimulus stream:
//   a: PATTERN 1011, overlap on,  COUNT_W 8
//   b: PATTERN 1011, overlap off, COUNT_W 8
//   c: PATTERN 11,   overlap on,  COUNT_W 2
// The reference model keeps the recent valid bits as a shift history and
// declares a match when the newest PATTERN_LEN bits since the last restart
// point equal the pattern.
module tb_moore_pattern_detector;

  logic clk;
  logic rst;
  logic clr;
  logic x;
  logic xv;
  logic y_a, y_b, y_c;
  logic p_a, p_b, p_c;
`ifdef MATCH_COUNT_EN
  logic [7:0] c_a, c_b;
  logic [1:0] c_c;
`endif

  moore_pattern_detector #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(1), .COUNT_W(8)) dut_a (
    .clock(clk), .reset(rst), .x(x), .x_valid(xv), .clear(clr),
    .y(y_a), .match_pulse(p_a)
`ifdef MATCH_COUNT_EN
    , .match_count(c_a)
`endif
  );

  moore_pattern_detector #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(0), .COUNT_W(8)) dut_b (
    .clock(clk), .reset(rst), .x(x), .x_valid(xv), .clear(clr),
    .y(y_b), .match_pulse(p_b)
`ifdef MATCH_COUNT_EN
    , .match_count(c_b)
`endif
  );

  moore_pattern_detector #(.PATTERN_LEN(2), .PATTERN(2'b11), .OVERLAP(1), .COUNT_W(2)) dut_c (
    .clock(clk), .reset(rst), .x(x), .x_valid(xv), .clear(clr),
    .y(y_c), .match_pulse(p_c)
`ifdef MATCH_COUNT_EN
    , .match_count(c_c)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] y;
    logic [2:0] p;
    logic [7:0] c0;
    logic [7:0] c1;
    logic [1:0] c2;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          plen [3] = '{4, 4, 2};
  logic [31:0] ppat [3] = '{32'b1011, 32'b1011, 32'b11};
  int          povl [3] = '{1, 0, 1};
  int          pmax [3] = '{255, 255, 3};
  logic [31:0] hist [3];
  int          hlen [3];
  logic        my   [3];
  int          mcnt [3];

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  task automatic step(input logic r, input logic c, input logic v, input logic b);
    exp_t e;
    logic hit;
    logic [31:0] mask;
    @(negedge clk);
    rst = r; clr = c; xv = v; x = b;
    e = '0;
    for (int d = 0; d < 3; d++) begin
      mask = (32'd1 << plen[d]) - 32'd1;
      if (r || c) begin
        hist[d] = '0; hlen[d] = 0; my[d] = 1'b0; mcnt[d] = 0;
      end else if (v) begin
        hist[d] = {hist[d][30:0], b};
        hlen[d]++;
        hit = (hlen[d] >= plen[d]) && (((hist[d] ^ ppat[d]) & mask) == 32'd0);
        my[d]  = hit;
        e.p[d] = hit;
        if (hit) begin
          if (mcnt[d] < pmax[d]) mcnt[d]++;
          if (povl[d] == 0) hlen[d] = 0;
        end
      end
      e.y[d] = my[d];
    end
    e.c0 = 8'(mcnt[0]);
    e.c1 = 8'(mcnt[1]);
    e.c2 = 2'(mcnt[2]);
    exp_q.push_back(e);
  endtask

  task automatic bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b0, 1'b1, v[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: outputs are presented every cycle; compare each against the
  // entry queued for that edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("y_a", int'(y_a), int'(e.y[0]));
      chk("y_b", int'(y_b), int'(e.y[1]));
      chk("y_c", int'(y_c), int'(e.y[2]));
      chk("pulse_a", int'(p_a), int'(e.p[0]));
      chk("pulse_b", int'(p_b), int'(e.p[1]));
      chk("pulse_c", int'(p_c), int'(e.p[2]));
`ifdef MATCH_COUNT_EN
      chk("count_a", int'(c_a), int'(e.c0));
      chk("count_b", int'(c_b), int'(e.c1));
      chk("count_c", int'(c_c), int'(e.c2));
`endif
    end
  end

  initial begin
    rst = 1'b1; clr = 1'b0; xv = 1'b0; x = 1'b0;
    // Reset state, with x_valid asserted to show it is overridden
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    // Overlapping / non-overlapping: 1,0,1,1,0,1,1
    bits(16'b1011011, 7);
    idle(2);
    // Gapped bits with trailing idle cycles
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1); idle(3);
    step(1'b0, 1'b0, 1'b1, 1'b0); idle(3);
    step(1'b0, 1'b0, 1'b1, 1'b1); idle(3);
    step(1'b0, 1'b0, 1'b1, 1'b1); idle(4);
    // Reset after 1,0,1 (valid 1 discarded), then 1 and 0,1,1 completes a match
    step(1'b0, 1'b1, 1'b0, 1'b0);
    bits(16'b101, 3);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    bits(16'b1, 1);
    idle(1);
    bits(16'b011, 3);
    // Saturation on the 2-bit counter: six ones give five matches of 11
    step(1'b0, 1'b1, 1'b0, 1'b0);
    bits(16'b111111, 6);
    idle(2);
    // Clear together with the final pattern bit
    step(1'b0, 1'b1, 1'b0, 1'b0);
    bits(16'b101, 3);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    idle(2);
    // Reset in the middle of a match
    bits(16'b1011, 4);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(1);
    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 79) == 0),
           ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end
    idle(2);
    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
